// File: rtl/gs_wb_arbiter.sv
// Writeback arbiter: round-robin sharing of the single register-file write port
// between NUM_REQ sources, with a registered write port and x0 write suppression.
module gs_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*5-1:0]  req_rd_addr,
    input  logic [NUM_REQ*32-1:0] req_rd_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rd_wen,
    output logic [4:0]            rd_addr,
    output logic [31:0]           rd_data,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    function automatic logic [31:0] count_ones(input logic [NUM_REQ-1:0] vec);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            n = n + 32'(vec[i]);
        end
        return n;
    endfunction

    logic [PTR_W-1:0]   rr_ptr_r;
    logic               rd_wen_r;
    logic [4:0]         rd_addr_r;
    logic [31:0]        rd_data_r;
    logic [CNT_W-1:0]   stall_cnt_r;

    logic               grant_hit_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               xfer_s;
    logic               multi_s;
    logic               cnt_max_s;
    logic [4:0]         sel_addr_s;
    logic [31:0]        sel_data_s;

    // Scan sources starting at rr_ptr, wrapping, and pick the first valid one.
    always_comb begin
        logic [PTR_W:0] pos;
        pos         = '0;
        grant_hit_s = 1'b0;
        grant_idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_r} + (PTR_W + 1)'(k);
            if (pos >= NUM_REQ_W) begin
                pos = pos - NUM_REQ_W;
            end else begin
                pos = pos;
            end
            if (!grant_hit_s && req_valid[pos[PTR_W-1:0]]) begin
                grant_hit_s = 1'b1;
                grant_idx_s = pos[PTR_W-1:0];
            end else begin
                grant_hit_s = grant_hit_s;
            end
        end
    end

    // One-hot grant, blocked entirely during reset or flush.
    always_comb begin
        grant_s = '0;
        if (!rst && !flush && grant_hit_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // AND-OR mux of the granted source's address and data.
    always_comb begin
        sel_addr_s = 5'd0;
        sel_data_s = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_addr_s = sel_addr_s | req_rd_addr[5*i +: 5];
                sel_data_s = sel_data_s | req_rd_data[32*i +: 32];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    assign xfer_s    = |grant_s;
    assign multi_s   = (count_ones(req_valid) >= 32'd2);
    assign cnt_max_s = (stall_cnt_r == {CNT_W{1'b1}});

    // Round-robin pointer: moves past the winner only when a transfer happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (xfer_s) begin
            rr_ptr_r <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + PTR_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Write port register; x0 targets are consumed but never enabled, since the
    // register-file bypass matches on address alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wen_r  <= 1'b0;
            rd_addr_r <= 5'd0;
            rd_data_r <= 32'd0;
        end else if (xfer_s) begin
            rd_wen_r  <= (sel_addr_s != 5'd0);
            rd_addr_r <= sel_addr_s;
            rd_data_r <= sel_data_s;
        end else begin
            rd_wen_r  <= 1'b0;
            rd_addr_r <= rd_addr_r;
            rd_data_r <= rd_data_r;
        end
    end

    // Saturating count of contended cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (!flush && multi_s && !cnt_max_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign req_ready = grant_s;
    assign rd_wen    = rd_wen_r;
    assign rd_addr   = rd_addr_r;
    assign rd_data   = rd_data_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_gs_wb_arbiter.sv
// Bench for gs_wb_arbiter: directed scenarios then random traffic, all checked
// against a round-robin reference model computed cycle by cycle.
module tb_gs_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  req_valid;
    logic [14:0] req_rd_addr;
    logic [95:0] req_rd_data;

    logic [2:0]  req_ready;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [15:0] stall_cnt;

    logic [2:0]  req_ready_b;
    logic        rd_wen_b;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic [3:0]  stall_cnt_b;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model state
    int          m_ptr = 0;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_stall;
    int          m_stall4;
    int          last_grant;
    logic [2:0]  ready_seen;

    always #5 clk = ~clk;

    gs_wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_rd_addr(req_rd_addr), .req_rd_data(req_rd_data),
        .req_ready(req_ready), .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data),
        .stall_cnt(stall_cnt)
    );

    gs_wb_arbiter #(.NUM_REQ(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_rd_addr(req_rd_addr), .req_rd_data(req_rd_data),
        .req_ready(req_ready_b), .rd_wen(rd_wen_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .stall_cnt(stall_cnt_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check grant, advance the model, check outputs.
    task automatic cycle(input logic r, input logic f, input logic [2:0] v,
                         input logic [14:0] a, input logic [95:0] d);
        int g;
        int pc;
        logic [2:0] exp_ready;
        rst = r; flush = f; req_valid = v; req_rd_addr = a; req_rd_data = d;
        #2;
        g = -1;
        if (!r && !f) begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
        end
        exp_ready = 3'b000;
        if (g >= 0) exp_ready[g] = 1'b1;
        ready_seen = req_ready;
        check_eq("req_ready", {61'd0, req_ready}, {61'd0, exp_ready});
        check_eq("req_ready_b", {61'd0, req_ready_b}, {61'd0, exp_ready});
        if (r) begin
            m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0;
            m_ptr = 0; m_stall = 0; m_stall4 = 0;
        end else begin
            pc = $countones(v);
            if (!f && pc >= 2) begin
                m_stall  = (m_stall  < 65535) ? m_stall  + 1 : 65535;
                m_stall4 = (m_stall4 < 15)    ? m_stall4 + 1 : 15;
            end
            if (g >= 0) begin
                m_addr = a[5*g +: 5];
                m_data = d[32*g +: 32];
                m_wen  = (m_addr != 5'd0);
                m_ptr  = (g + 1) % 3;
            end else begin
                m_wen = 1'b0;
            end
        end
        last_grant = g;
        @(posedge clk);
        #1;
        check_eq("rd_wen", {63'd0, rd_wen}, {63'd0, m_wen});
        check_eq("rd_addr", {59'd0, rd_addr}, {59'd0, m_addr});
        check_eq("rd_data", {32'd0, rd_data}, {32'd0, m_data});
        check_eq("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
        check_eq("stall_cnt_b", {60'd0, stall_cnt_b}, 64'(m_stall4));
    endtask

    logic [2:0]  pv;
    logic [4:0]  pa [3];
    logic [31:0] pd [3];
    logic        r_s;
    logic        f_s;

    initial begin
        // reset with all sources requesting
        cycle(1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
        check_eq("reset_ready", {61'd0, ready_seen}, 64'd0);
        cycle(1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA});
        check_eq("reset_wen", {63'd0, rd_wen}, 64'd0);
        check_eq("reset_stall", {48'd0, stall_cnt}, 64'd0);

        // round-robin under full contention
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3333, 32'h2222, 32'h1111});
            check_eq("rr_seq", {61'd0, ready_seen}, 64'(3'b001 << (i % 3)));
        end
        check_eq("rr_stall", {48'd0, stall_cnt}, 64'd6);

        // single source
        cycle(1'b0, 1'b0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0});
        check_eq("single_ready", {61'd0, ready_seen}, 64'd2);
        check_eq("single_wen", {63'd0, rd_wen}, 64'd1);
        check_eq("single_addr", {59'd0, rd_addr}, 64'd5);
        check_eq("single_data", {32'd0, rd_data}, 64'hDEAD_BEEF);

        // x0 write consumed but suppressed
        cycle(1'b0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'd1});
        check_eq("x0_ready", {61'd0, ready_seen}, 64'd1);
        check_eq("x0_wen", {63'd0, rd_wen}, 64'd0);
        check_eq("x0_data", {32'd0, rd_data}, 64'd1);

        // flush blocks, next cycle grants
        cycle(1'b0, 1'b1, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'd0, 32'd0});
        check_eq("flush_ready", {61'd0, ready_seen}, 64'd0);
        check_eq("flush_wen", {63'd0, rd_wen}, 64'd0);
        cycle(1'b0, 1'b0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'd0, 32'd0});
        check_eq("post_flush_ready", {61'd0, ready_seen}, 64'd4);
        check_eq("post_flush_addr", {59'd0, rd_addr}, 64'd7);

        // saturation of the narrow counter
        cycle(1'b1, 1'b0, 3'b000, 15'd0, 96'd0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 3'b011, {5'd0, 5'd9, 5'd8}, {32'd0, 32'h99, 32'h88});
        end
        check_eq("sat_stall_b", {60'd0, stall_cnt_b}, 64'd15);
        check_eq("sat_stall", {48'd0, stall_cnt}, 64'd20);

        // random traffic; pending requests hold until granted
        pv = 3'b000;
        for (int i = 0; i < 3; i++) begin
            pa[i] = 5'd0;
            pd[i] = 32'd0;
        end
        for (int n = 0; n < 400; n++) begin
            r_s = ($urandom_range(0, 59) == 0);
            f_s = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!pv[i]) begin
                    pv[i] = ($urandom_range(0, 99) < 50);
                    pa[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pd[i] = $urandom;
                end
            end
            cycle(r_s, f_s, pv, {pa[2], pa[1], pa[0]}, {pd[2], pd[1], pd[0]});
            if (r_s) begin
                pv = 3'b000;
            end else if (last_grant >= 0) begin
                pv[last_grant] = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
